// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_RSVD = 2'd3
  } t_parity;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } t_tx_state;

  // Reserved parity code behaves exactly like "none".
  function automatic logic parity_en(input t_parity par);
    return (par == PAR_EVEN) || (par == PAR_ODD);
  endfunction

  // Data is zero-extended to the widest frame; extra zeros do not disturb the XOR.
  function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] dat, input t_parity par);
    return (^dat) ^ (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: down-counter reloaded at every bit boundary, one-cycle TICK in the last cycle of a bit.
// Latency: RESTART at edge t makes the first bit end CLKDIV+1 cycles later; divisor is frozen at RESTART.
// Backpressure: none; free-running between restarts.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             SRSTN,
  input  logic [DIV_W-1:0] CLKDIV,
  input  logic             RESTART,
  output logic             TICK,
  output logic             TICK_NXT
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  // Count down through the bit; reload from the frame's frozen divisor at each boundary.
  always_ff @(posedge CLK or negedge SRSTN) begin
    if (!SRSTN) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (RESTART) begin
      cnt   <= CLKDIV;
      div_q <= CLKDIV;
    end else if (cnt == '0) begin
      cnt <= div_q;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  // TICK marks the final cycle of a bit; TICK_NXT says the next cycle will be one
  // (ignores RESTART, which only ever leads into a start bit).
  assign TICK     = (cnt == '0);
  assign TICK_NXT = TICK ? (div_q == '0) : (cnt == DIV_W'(1));

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with compile-time data width, run-time parity/stop config and a one-entry holding buffer.
// Latency: transfer at edge t while idle drives the start bit from edge t+1; frames chain with no idle bit.
// Backpressure: READY low while the holding buffer is occupied; it frees when the FSM loads a frame.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              CLK,
  input  logic              SRSTN,
  input  logic [DIV_W-1:0]  CLKDIV,
  input  logic [1:0]        PARITY,
  input  logic              STOP2,
  input  logic [DATA_W-1:0] DATA,
  input  logic              VALID,
  output logic              READY,
  output logic              SERIAL,
  output logic              BUSY,
  output logic              DONE
);

  localparam int              IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  if ((DATA_W < DATA_W_MIN) || (DATA_W > DATA_W_MAX)) begin : g_bad_data_w
    $error("uart_tx_cfg: DATA_W must be within 5..9");
  end

  // Holding buffer; READY doubles as its empty flag.
  logic              buf_vld;
  logic [DATA_W-1:0] buf_dat;
  t_parity           buf_par;
  logic              buf_stop2;

  // Per-frame state, captured when the FSM loads a frame.
  t_tx_state         state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic              par_bit;
  logic              par_en;
  logic              stop2_f;
  logic              stop_idx;

  logic              tick;
  logic              tick_nxt;
  logic              stop_last;
  logic              frame_end;
  logic              start_idle;
  logic              start_b2b;
  logic              frame_load;
  logic              bypass;
  logic              take;
  logic              enter_stop;
  logic              done_nxt;
  logic [DATA_W-1:0] ld_dat;
  t_parity           ld_par;
  logic              ld_stop2;

  assign buf_vld = ~READY;

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud (
    .CLK      (CLK),
    .SRSTN    (SRSTN),
    .CLKDIV   (CLKDIV),
    .RESTART  (frame_load),
    .TICK     (tick),
    .TICK_NXT (tick_nxt)
  );

  // Frame sequencing decisions. A transfer in the DONE cycle goes straight into
  // the next frame (bypassing the buffer) so the link never shows an idle bit.
  always_comb begin
    stop_last  = ~stop2_f | stop_idx;
    frame_end  = (state == S_STOP) && tick && stop_last;
    start_idle = (state == S_IDLE) && buf_vld;
    start_b2b  = frame_end && (buf_vld || VALID);
    frame_load = start_idle || start_b2b;
    bypass     = start_b2b && !buf_vld;
    take       = VALID && READY;
    ld_dat     = buf_vld ? buf_dat   : DATA;
    ld_par     = buf_vld ? buf_par   : t_parity'(PARITY);
    ld_stop2   = buf_vld ? buf_stop2 : STOP2;
    enter_stop = tick && (((state == S_DATA) && (bit_idx == LAST_IDX) && !par_en) ||
                          (state == S_PARITY));
    // DONE is registered, so raise it on the edge that enters the last cycle of the last stop bit.
    done_nxt   = tick_nxt && (((state == S_STOP) && (tick ? !stop_last : stop_last)) ||
                              (enter_stop && !stop2_f));
  end

  // Holding buffer: capture on handshake, release when the FSM takes the entry.
  always_ff @(posedge CLK or negedge SRSTN) begin
    if (!SRSTN) begin
      READY     <= 1'b1;
      buf_dat   <= '0;
      buf_par   <= PAR_NONE;
      buf_stop2 <= 1'b0;
    end else if (take && !bypass) begin
      READY     <= 1'b0;
      buf_dat   <= DATA;
      buf_par   <= t_parity'(PARITY);
      buf_stop2 <= STOP2;
    end else if (frame_load && buf_vld) begin
      READY <= 1'b1;
    end
  end

  // Transmit FSM with registered SERIAL/BUSY/DONE.
  always_ff @(posedge CLK or negedge SRSTN) begin
    if (!SRSTN) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      par_bit  <= 1'b0;
      par_en   <= 1'b0;
      stop2_f  <= 1'b0;
      stop_idx <= 1'b0;
      SERIAL   <= 1'b1;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= done_nxt;
      if (frame_load) begin
        shreg   <= ld_dat;
        par_en  <= parity_en(ld_par);
        par_bit <= parity_bit(DATA_W_MAX'(ld_dat), ld_par);
        stop2_f <= ld_stop2;
      end
      case (state)
        S_IDLE: begin
          SERIAL <= 1'b1;
          if (start_idle) begin
            state  <= S_START;
            SERIAL <= 1'b0;
            BUSY   <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            state   <= S_DATA;
            SERIAL  <= shreg[0];
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_IDX) begin
              if (par_en) begin
                state  <= S_PARITY;
                SERIAL <= par_bit;
              end else begin
                state    <= S_STOP;
                SERIAL   <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              shreg   <= shreg >> 1;
              SERIAL  <= shreg[1];
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            state    <= S_STOP;
            SERIAL   <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (stop_last) begin
              if (start_b2b) begin
                state  <= S_START;
                SERIAL <= 1'b0;
              end else begin
                state <= S_IDLE;
                BUSY  <= 1'b0;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          SERIAL <= 1'b1;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg (DATA_W=8 main instance plus a DATA_W=5 instance).
// Latency: n/a.
// Backpressure: driver honours READY; monitor scoreboards every frame cycle-by-cycle.
module tb_uart_tx_cfg;

  logic        CLK    = 1'b0;
  logic        SRSTN  = 1'b0;
  logic [15:0] CLKDIV = '0;
  logic [1:0]  PARITY = '0;
  logic        STOP2  = 1'b0;
  logic [7:0]  DATA   = '0;
  logic        VALID  = 1'b0;
  logic        READY, SERIAL, BUSY, DONE;

  logic [4:0]  DATA5  = '0;
  logic        VALID5 = 1'b0;
  logic        READY5, SERIAL5, BUSY5, DONE5;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          div;
  } exp_t;

  exp_t exp_q[$];
  exp_t q5[$];
  int   gap_q[$];
  int   frames_done = 0;
  int   spur_start  = 0;
  int   idle_done   = 0;
  int   idle_busy   = 0;

  always #5 CLK = ~CLK;

  uart_tx_cfg #(.DATA_W(8), .DIV_W(16)) u_dut (
    .CLK    (CLK),
    .SRSTN  (SRSTN),
    .CLKDIV (CLKDIV),
    .PARITY (PARITY),
    .STOP2  (STOP2),
    .DATA   (DATA),
    .VALID  (VALID),
    .READY  (READY),
    .SERIAL (SERIAL),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  uart_tx_cfg #(.DATA_W(5), .DIV_W(16)) u_dut5 (
    .CLK    (CLK),
    .SRSTN  (SRSTN),
    .CLKDIV (16'd1),
    .PARITY (2'd2),
    .STOP2  (1'b0),
    .DATA   (DATA5),
    .VALID  (VALID5),
    .READY  (READY5),
    .SERIAL (SERIAL5),
    .BUSY   (BUSY5),
    .DONE   (DONE5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame model: start, data LSB first, optional parity, 1 or 2 stop bits.
  function automatic exp_t make_exp(input logic [8:0] d, input int w, input logic [1:0] p,
                                    input logic s2, input int div);
    exp_t e;
    int   n;
    logic par;
    e.bits = '0;
    n      = 1;
    par    = 1'b0;
    for (int i = 0; i < w; i++) begin
      e.bits[n] = d[i];
      par       = par ^ d[i];
      n++;
    end
    if (p == 2'd1 || p == 2'd2) begin
      e.bits[n] = par ^ (p == 2'd2);
      n++;
    end
    e.bits[n] = 1'b1;
    n++;
    if (s2) begin
      e.bits[n] = 1'b1;
      n++;
    end
    e.nbits = n;
    e.div   = div;
    return e;
  endfunction

  task automatic send(input logic [7:0] d, input logic hold);
    int n;
    n     = 0;
    DATA  = d;
    VALID = 1'b1;
    while (!READY && n < 5000) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 5000) chk("send_timeout", 32'(READY), 1);
    exp_q.push_back(make_exp({1'b0, d}, 8, PARITY, STOP2, int'(CLKDIV)));
    @(posedge CLK); #1;
    if (!hold) VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while ((exp_q.size() != 0 || BUSY) && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 5000) chk("idle_timeout", 32'(BUSY), 0);
    @(negedge CLK);
  endtask

  // Monitor: on each start bit pop the expected frame and check it cycle by cycle.
  initial begin : monitor
    exp_t        e;
    logic [15:0] obs;
    int          unst, dcnt, done_at, blow, tot_c, gap, per;
    logic        abrt;
    gap = 0;
    forever begin
      @(negedge CLK);
      if (!SRSTN) begin
        gap = 0;
      end else if (SERIAL == 1'b0) begin
        if (exp_q.size() == 0) begin
          spur_start++;
        end else begin
          e = exp_q.pop_front();
          gap_q.push_back(gap);
          gap     = 0;
          obs     = '0;
          unst    = 0;
          dcnt    = 0;
          done_at = -1;
          blow    = 0;
          abrt    = 1'b0;
          per     = e.div + 1;
          tot_c   = e.nbits * per;
          for (int c = 0; c < tot_c; c++) begin
            if (c > 0) @(negedge CLK);
            if (!SRSTN) begin
              abrt = 1'b1;
              break;
            end
            if (c % per == 0) obs[c / per] = SERIAL;
            else if (SERIAL != obs[c / per]) unst++;
            if (DONE) begin
              dcnt++;
              done_at = c;
            end
            if (!BUSY) blow++;
          end
          if (!abrt) begin
            chk("frame_bits", 32'(obs), 32'(e.bits));
            chk("bit_stable", unst, 0);
            chk("done_count", dcnt, 1);
            chk("done_pos", done_at, tot_c - 1);
            chk("busy_in_frame", blow, 0);
            frames_done++;
          end
        end
      end else begin
        gap++;
        if (DONE) idle_done++;
        if (BUSY) idle_busy++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   fd, n, c5, d5cnt, d5at, b5cnt;
    logic [15:0] obs5;
    exp_t e5;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_serial", 32'(SERIAL), 1);
    chk("rst_ready",  32'(READY),  1);
    chk("rst_busy",   32'(BUSY),   0);
    chk("rst_done",   32'(DONE),   0);
    @(negedge CLK);
    SRSTN = 1'b1;
    @(posedge CLK); #1;

    // 8N1, 4 cycles per bit, start-bit latency
    CLKDIV = 16'd3;
    PARITY = 2'd0;
    STOP2  = 1'b0;
    send(8'hA5, 1'b0);
    chk("lat_serial_idle", 32'(SERIAL), 1);
    chk("lat_busy_idle",   32'(BUSY),   0);
    @(posedge CLK); #1;
    chk("lat_start",  32'(SERIAL), 0);
    chk("lat_busy",   32'(BUSY),   1);
    chk("ready_free", 32'(READY),  1);
    wait_idle();

    // Even then odd parity
    CLKDIV = 16'd1;
    PARITY = 2'd1;
    send(8'hA5, 1'b0);
    wait_idle();
    PARITY = 2'd2;
    send(8'hA5, 1'b0);
    wait_idle();

    // Two stop bits, one cycle per bit
    PARITY = 2'd0;
    STOP2  = 1'b1;
    CLKDIV = 16'd0;
    send(8'h00, 1'b0);
    wait_idle();
    STOP2 = 1'b0;

    // Back-to-back with VALID held high
    CLKDIV = 16'd2;
    send(8'h55, 1'b1);
    send(8'h0F, 1'b0);
    chk("b2b_buf_full", 32'(READY), 0);
    wait_idle();
    chk("b2b_gap", gap_q[gap_q.size()-1], 0);
    chk("b2b_frames", frames_done, 6);

    // Transfer in the DONE cycle chains with no idle bit
    CLKDIV = 16'd1;
    send(8'h81, 1'b0);
    n = 0;
    @(negedge CLK);
    while (!DONE && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk("bypass_done_seen", 32'(DONE),  1);
    chk("bypass_ready",     32'(READY), 1);
    DATA  = 8'h7E;
    VALID = 1'b1;
    exp_q.push_back(make_exp({1'b0, 8'h7E}, 8, PARITY, STOP2, int'(CLKDIV)));
    @(posedge CLK); #1;
    VALID = 1'b0;
    wait_idle();
    chk("bypass_gap", gap_q[gap_q.size()-1], 0);

    // CLKDIV change mid-frame must not affect the running frame
    CLKDIV = 16'd2;
    send(8'h3C, 1'b0);
    repeat (5) @(posedge CLK);
    CLKDIV = 16'd7;
    wait_idle();

    // Reset mid-data with a second byte buffered
    CLKDIV = 16'd3;
    send(8'h33, 1'b1);
    send(8'hCC, 1'b0);
    chk("rst_buf_full", 32'(READY), 0);
    repeat (14) @(posedge CLK);
    #2;
    SRSTN = 1'b0;
    #1;
    chk("arst_serial", 32'(SERIAL), 1);
    chk("arst_ready",  32'(READY),  1);
    chk("arst_busy",   32'(BUSY),   0);
    chk("arst_done",   32'(DONE),   0);
    exp_q.delete();
    repeat (2) @(negedge CLK);
    SRSTN = 1'b1;
    fd = frames_done;
    repeat (60) @(negedge CLK);
    chk("rst_no_frames", frames_done, fd);
    chk("rst_no_start",  spur_start, 0);
    chk("rst_idle_line", 32'(SERIAL), 1);
    chk("rst_idle_busy", 32'(BUSY),   0);
    send(8'h5A, 1'b0);
    wait_idle();

    // DATA_W=5 instance: 5'h13 with odd parity, CLKDIV=1
    chk("d5_ready", 32'(READY5), 1);
    DATA5  = 5'h13;
    VALID5 = 1'b1;
    q5.push_back(make_exp({4'b0, 5'h13}, 5, 2'd2, 1'b0, 1));
    @(posedge CLK); #1;
    VALID5 = 1'b0;
    chk("d5_lat_idle", 32'(SERIAL5), 1);
    obs5  = '0;
    d5cnt = 0;
    d5at  = -1;
    b5cnt = 0;
    c5    = q5[0].nbits * (q5[0].div + 1);
    for (int c = 0; c < c5; c++) begin
      @(posedge CLK); #1;
      if (c % 2 == 0) obs5[c / 2] = SERIAL5;
      if (DONE5) begin
        d5cnt++;
        d5at = c;
      end
      if (BUSY5) b5cnt++;
    end
    e5 = q5.pop_front();
    chk("d5_frame",   32'(obs5), 32'(e5.bits));
    chk("d5_nbits",   e5.nbits, 8);
    chk("d5_done",    d5cnt, 1);
    chk("d5_done_at", d5at, 15);
    chk("d5_busy",    b5cnt, 16);
    @(posedge CLK); #1;
    chk("d5_end_busy",   32'(BUSY5),   0);
    chk("d5_end_serial", 32'(SERIAL5), 1);

    // Final bookkeeping
    chk("q_empty",    exp_q.size(), 0);
    chk("spur_start", spur_start, 0);
    chk("idle_done",  idle_done, 0);
    chk("idle_busy",  idle_busy, 0);
    chk("frames",     frames_done, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
